// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for the shared N:1 mux tree: one owner at a time, binary select,
// valid/ready beat transfer, forced rotation after MAX_HOLD beats.
module rr_mux_arbiter #(
  parameter int N = 8,
  parameter int W = 1,
  parameter int MAX_HOLD = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  input  logic           ready,
  output logic [N-1:0]   gnt,
  output logic [SW-1:0]  sel,
  output logic [W-1:0]   dout,
  output logic           dout_valid,
  output logic [N-1:0]   ack
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [SW-1:0] sel_nxt, ptr, ptr_nxt, ptr_inc;
  logic [7:0]    cnt, cnt_nxt;
  logic [W-1:0]  lane [N];
  logic          xfer, rel_drop, rel_hold;
  logic [N-1:0]  rel_mask;
  logic [SW:0]   pick_idle, pick_rel;

  // Returns {found, index} of the first requester at or after p, wrapping at N.
  function automatic logic [SW:0] arbitrate(input logic [N-1:0] r, input logic [SW-1:0] p);
    logic [SW-1:0] idx;
    arbitrate = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = p + SW'(k);
      if (r[idx]) arbitrate = {1'b1, idx};
    end
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) lane[i] = din[i*W +: W];
  end

  assign dout_valid = (state == GRANT) && req[sel];
  assign dout       = dout_valid ? lane[sel] : '0;
  assign xfer       = dout_valid && ready;
  assign ack        = gnt & {N{xfer}};

  assign rel_drop  = (state == GRANT) && !req[sel];
  assign rel_hold  = xfer && (cnt == 8'(MAX_HOLD - 1));
  assign ptr_inc   = sel + SW'(1);
  // A dropped owner is masked out; a hold-limited owner is scanned last and wins only if alone.
  assign rel_mask  = rel_drop ? (req & ~gnt) : req;
  assign pick_idle = arbitrate(req, ptr);
  assign pick_rel  = arbitrate(rel_mask, ptr_inc);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pick_idle[SW]) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idle[SW-1:0];
          gnt_nxt   = N'(1) << pick_idle[SW-1:0];
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (rel_drop || rel_hold) begin
          ptr_nxt = ptr_inc;
          cnt_nxt = '0;
          if (pick_rel[SW]) begin
            sel_nxt = pick_rel[SW-1:0];
            gnt_nxt = N'(1) << pick_rel[SW-1:0];
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (xfer) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: cycle vector table on a MAX_HOLD=4 instance, reset corner case,
// and a fairness scoreboard on a MAX_HOLD=2 instance.
module tb_rr_mux_arbiter;
  localparam int N = 8;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req, req2;
  logic [N*W-1:0] din;
  logic           ready, ready2;
  logic [N-1:0]   gnt, gnt2, ack, ack2;
  logic [2:0]     sel, sel2;
  logic [W-1:0]   dout, dout2;
  logic           dout_valid, dout_valid2;

  rr_mux_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .ready(ready),
    .gnt(gnt), .sel(sel), .dout(dout), .dout_valid(dout_valid), .ack(ack)
  );

  rr_mux_arbiter #(.N(N), .W(W), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .din(din), .ready(ready2),
    .gnt(gnt2), .sel(sel2), .dout(dout2), .dout_valid(dout_valid2), .ack(ack2)
  );

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic [7:0] ack;
    logic [7:0] cnt;
    logic [2:0] ptr;
  } vec_t;

  vec_t vecs[$];
  int   exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lane_acks [N];

  function automatic vec_t mk(logic [7:0] r, logic rd, logic [7:0] g, logic [2:0] s,
                              logic v, logic [7:0] a, logic [7:0] c, logic [2:0] p);
    vec_t t;
    t.req = r; t.ready = rd; t.gnt = g; t.sel = s; t.valid = v; t.ack = a; t.cnt = c; t.ptr = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp_lane;
    // lane i carries i+1
    din = 32'h8765_4321;
    rst_n = 1'b0; req = '0; ready = 1'b1; req2 = '0; ready2 = 1'b1;

    //           req    rdy  gnt    sel v  ack    cnt ptr
    vecs.push_back(mk(8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(8'h04, 1, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(8'h04, 1, 8'h04, 2, 1, 8'h04, 0, 0));
    vecs.push_back(mk(8'h04, 1, 8'h04, 2, 1, 8'h04, 1, 0));
    vecs.push_back(mk(8'h04, 1, 8'h04, 2, 1, 8'h04, 2, 0));
    vecs.push_back(mk(8'h04, 1, 8'h04, 2, 1, 8'h04, 3, 0));
    vecs.push_back(mk(8'h04, 1, 8'h04, 2, 1, 8'h04, 0, 3));
    vecs.push_back(mk(8'h04, 1, 8'h04, 2, 1, 8'h04, 1, 3));
    vecs.push_back(mk(8'h00, 1, 8'h04, 2, 0, 8'h00, 2, 3));
    vecs.push_back(mk(8'h00, 1, 8'h00, 2, 0, 8'h00, 0, 3));
    vecs.push_back(mk(8'h08, 0, 8'h00, 2, 0, 8'h00, 0, 3));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(8'h08, 0, 8'h08, 3, 1, 8'h00, 0, 3));
    vecs.push_back(mk(8'h08, 1, 8'h08, 3, 1, 8'h08, 0, 3));
    vecs.push_back(mk(8'h08, 1, 8'h08, 3, 1, 8'h08, 1, 3));
    vecs.push_back(mk(8'h0A, 1, 8'h08, 3, 1, 8'h08, 2, 3));
    vecs.push_back(mk(8'h0A, 1, 8'h08, 3, 1, 8'h08, 3, 3));
    vecs.push_back(mk(8'h02, 1, 8'h02, 1, 1, 8'h02, 0, 4));
    vecs.push_back(mk(8'h20, 1, 8'h02, 1, 0, 8'h00, 1, 4));
    vecs.push_back(mk(8'h22, 1, 8'h20, 5, 1, 8'h20, 0, 2));
    vecs.push_back(mk(8'h02, 1, 8'h20, 5, 0, 8'h00, 1, 2));
    vecs.push_back(mk(8'h02, 1, 8'h02, 1, 1, 8'h02, 0, 6));
    vecs.push_back(mk(8'h02, 0, 8'h02, 1, 1, 8'h00, 1, 6));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req = vecs[i].req;
      ready = vecs[i].ready;
      #1;
      chk($sformatf("v%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("v%0d_sel", i), sel, vecs[i].sel);
      chk($sformatf("v%0d_valid", i), dout_valid, vecs[i].valid);
      chk($sformatf("v%0d_ack", i), ack, vecs[i].ack);
      chk($sformatf("v%0d_dout", i), dout, vecs[i].valid ? 32'(vecs[i].sel) + 1 : 0);
      chk($sformatf("v%0d_cnt", i), dut.cnt, vecs[i].cnt);
      chk($sformatf("v%0d_ptr", i), dut.ptr, vecs[i].ptr);
      @(posedge clk);
      @(negedge clk);
    end

    // asynchronous reset in the middle of a grant to lane 1
    req = 8'h02; ready = 1'b1;
    #1;
    chk("pre_rst_valid", dout_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_dout", dout, 0);
    req = 8'h80;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle_gnt", gnt, 0);
    @(posedge clk);
    #1;
    chk("post_rst_gnt", gnt, 8'h80);
    chk("post_rst_sel", sel, 7);
    chk("post_rst_ptr", dut.ptr, 0);
    chk("post_rst_dout", dout, 8);
    @(negedge clk);
    req = '0;

    // fairness on the MAX_HOLD=2 instance: expected owner per accepted beat
    for (int i = 0; i < N; i++) begin
      lane_acks[i] = 0;
      exp_q.push_back(i);
      exp_q.push_back(i);
    end
    exp_q.push_back(0);
    req2 = 8'hFF;
    ready2 = 1'b1;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (ack2 != 0) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("rr_c%0d_extra_ack", c), ack2, 0);
        end else begin
          exp_lane = 3'(exp_q.pop_front());
          chk($sformatf("rr_c%0d_ack", c), ack2, 8'h01 << exp_lane);
          chk($sformatf("rr_c%0d_sel", c), sel2, exp_lane);
          chk($sformatf("rr_c%0d_dout", c), dout2, 32'(exp_lane) + 1);
        end
        if (c <= 16)
          for (int i = 0; i < N; i++) if (ack2[i]) lane_acks[i]++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("rr_missing_acks", exp_q.size(), 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("rr_lane%0d_acks", i), lane_acks[i], 2);
    req2 = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for the shared N:1 select tree in the mux library. Up to N requesters compete for one output lane. The block grants one requester at a time, drives the binary select of the mux tree, and moves data beats under a valid/ready handshake. A hold limit prevents any requester from starving the others.

## Interface
- N, default 8: number of requesters; a power of two from 2 to 16.
- W, default 1: data width per requester lane.
- MAX_HOLD, default 4: maximum number of beats per grant before forced rotation; range 1 to 255.
- SW: derived parameter, $clog2(N).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  N  request per requester; held high while the requester has beats to send.
- din  input  N*W  packed lane data; lane i occupies din[i*W +: W].
- ready  input  1  downstream accepts a beat this cycle.
- gnt  output  N  one-hot grant, registered.
- sel  output  SW  binary index of the granted lane, registered; drives the mux tree select.
- dout  output  W  selected lane data; forced to 0 when dout_valid is low.
- dout_valid  output  1  a beat is presented downstream.
- ack  output  N  per-requester beat accepted; ack[i] = gnt[i] & dout_valid & ready.

## Operation
- State machine states:
  - IDLE: gnt = 0.
  - GRANT: exactly one gnt bit is high; the owner is given by sel.
- Internal registers:
  - ptr (SW bits): round-robin priority start.
  - cnt (8 bits): beats sent in the current grant.
- Arbitration function: pick the first i with req[i] = 1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
- IDLE:
  - If req is nonzero, arbitrate. Next state is GRANT with gnt/sel = winner and cnt = 0.
  - Otherwise stay in IDLE.
- GRANT:
  - dout_valid = req[sel].
  - dout = din[sel*W +: W] while valid.
  - A transfer occurs when dout_valid & ready; it increments cnt.
- Release in GRANT happens when either:
  - (a) req[sel] = 0, or
  - (b) a transfer occurs with cnt = MAX_HOLD-1.
- On release:
  - ptr ← sel+1 (wraps at N).
  - Arbitrate the current req with the new ptr, excluding the releasing owner under condition (a).
  - If there is a winner, go to GRANT with the new owner and cnt = 0, with no IDLE bubble.
  - Otherwise go to IDLE. gnt and sel hold their old value until the edge.
- Under condition (b), the old owner can win again only if no other requester is asserting req. It then gets a fresh cnt = 0.
- While ready is low, the grant holds and cnt does not advance. There is no timeout.
- Requests arriving from non-owners mid-grant do not preempt the owner.
- sel changes only on a grant edge, so the mux tree select is glitch-free relative to clk.
- Reset (asynchronous, any time, including mid-grant):
  - Reset values: state = IDLE, gnt = 0, sel = 0, ptr = 0, cnt = 0.
  - Resulting outputs: dout_valid = 0, dout = 0, ack = 0.
  - No beat is in flight after reset.

## Timing
- Request-to-grant latency is 1 cycle: req is sampled at edge k, and gnt/sel/dout_valid are high after edge k.
- Owner handoff latency is 1 cycle, with no dead cycle between consecutive grants.
- dout_valid, dout and ack are combinational from registered sel/gnt and the live req, din and ready. There is no registered output stage.
- Throughput is one beat per cycle while the owner keeps req high and ready is high.
- req[i] may drop in any cycle. If it drops in the same cycle as the MAX_HOLD-th transfer, no beat is lost: dout_valid is already low in that cycle, so no transfer occurs.
- ptr advances only on release, never in IDLE.

## Test plan
- Single requester, N=8, MAX_HOLD=4:
  - Stimulus: req = 0x04 held 6 cycles, ready = 1.
  - Required: gnt = 0x04 and sel = 2 one cycle after req. Six ack pulses. After the 4th beat, the grant is re-issued to 2 with cnt = 0, with no gap.
- Round-robin fairness:
  - Stimulus: req = 0xFF constant, ready = 1, MAX_HOLD = 2.
  - Required: sel sequence 0,0,1,1,2,2,…,7,7,0. Each lane gets exactly 2 acks per 16 cycles.
- Backpressure:
  - Stimulus: owner 3 granted, ready low for 5 cycles.
  - Required: gnt and sel held, ack = 0, cnt frozen. Beats resume when ready rises.
- Early release:
  - Stimulus: owner 5 drops req after 1 beat while req[1] is high.
  - Required: on the next edge, gnt = 0x02, sel = 1, ptr = 6.
- Mid-grant reset:
  - Stimulus: assert rst_n = 0 between edges during GRANT.
  - Required: gnt, dout_valid and ack go to 0 immediately (asynchronous). After release of reset with req = 0x80, the first grant goes to 7 (ptr = 0 scan).
- Idle gap:
  - Stimulus: req returns to 0 after a grant.
  - Required: state is IDLE, gnt = 0, dout = 0, and sel holds its last value.
